ram_sized_access: RTL and testbench
===================================

Name: ram_sized_access

Overview:
- Parametrised successor to the single-cycle core's dual-port RAM.
- Instruction port: one asynchronous read port.
- Data port: one read/write port with byte, half-word and word access sizes; sign or zero extension on reads; misalignment and out-of-range detection.
- On reset, a clear state machine zeroes every word one per cycle while asserting init_busy; the core stalls on init_busy.

Parameters:
- DATA_WIDTH, 32, word width in bits; fixed at 32 because the byte-lane logic assumes 4 lanes.
- ADDR_WIDTH, 16, byte-address width of both ports.
- DEPTH, 1024, number of words; must be ≤ 2**(ADDR_WIDTH-2).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- i_address  input  ADDR_WIDTH  instruction byte address; bits [1:0] ignored.
- i_read_data  output  DATA_WIDTH  instruction word.
- wEn  input  1  data write enable.
- d_address  input  ADDR_WIDTH  data byte address.
- d_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- d_unsigned  input  1  1 = zero-extend sub-word reads, 0 = sign-extend.
- d_write_data  input  DATA_WIDTH  store data, LSB-justified.
- d_read_data  output  DATA_WIDTH  extended load data.
- d_misaligned  output  1  access is misaligned or d_size is illegal.
- d_out_of_range  output  1  word index ≥ DEPTH.
- init_busy  output  1  clear sequence in progress.

Behaviour:
- Word index is address[ADDR_WIDTH-1:2]. An index ≥ DEPTH is out of range.
- All reads are combinational from current inputs and array contents; there is no read latency.
- Instruction port:
  - i_read_data = mem[i index].
  - It is 0 if the index is out of range or init_busy=1.
- Misalignment (combinational):
  - d_misaligned = 1 for half with d_address[0]=1.
  - d_misaligned = 1 for word with d_address[1:0]≠00.
  - d_misaligned = 1 for d_size=11.
- d_out_of_range is combinational from d_address.
- Both flags are valid regardless of wEn.
- Data read:
  - Returns 0 when d_misaligned, d_out_of_range or init_busy is set.
  - Byte: lane d_address[1:0], bits [8k+7:8k]; extended per d_unsigned.
  - Half: lanes selected by d_address[1]; extended per d_unsigned.
  - Word: returns the whole word; d_unsigned is ignored.
- Data write:
  - Happens on the rising edge only when wEn=1, reset=0, init_busy=0, d_misaligned=0 and d_out_of_range=0.
  - Otherwise the array is unchanged. Faulted writes are dropped silently apart from the flags.
  - Byte: writes d_write_data[7:0] into lane d_address[1:0]; the other lanes are preserved.
  - Half: writes d_write_data[15:0] into lanes {2,3} if d_address[1]=1, else lanes {0,1}.
  - Word: writes the full word.
- Read-during-write: combinational reads show the old value until the edge and the new value after it. Both ports observe the same array.
- Clear FSM states: INIT, READY. The counter clr_idx is $clog2(DEPTH) bits.
  - Any edge with reset=1: state←INIT, clr_idx←0. No array write occurs on that edge.
  - INIT with reset=0: mem[clr_idx]←0 and clr_idx←clr_idx+1. When clr_idx=DEPTH-1, state←READY on that same edge.
  - READY: stays in READY until reset.
  - init_busy = (state==INIT), so it is 1 after the reset edge.
  - After reset deasserts, init_busy stays 1 for exactly DEPTH edges and reads 0 after the DEPTH-th edge.
- Reset mid-clear restarts from clr_idx=0. Words already cleared stay 0.
- State before the first reset is undefined; benches must apply reset first.

Test Plan:
- Assert reset for 2 cycles then release (DEPTH=1024) -> init_busy=1 for exactly 1024 edges then 0. A read of address 4 during clear gives 0. After clear, addresses 0, 4 and 4092 read 00000000.
- Byte and half writes:
  - Stimulus: SW 0x11223344 at 8, then SB 0xAA at 9, then SH 0xBEEF at 10.
  - Required: word read at 8 = BEEFAA44.
  - Required: LB at 9 with d_unsigned=0 = FFFFFFAA; with d_unsigned=1 = 000000AA.
  - Required: LH at 10 signed = FFFFBEEF.
  - Required: i_address=8 gives BEEFAA44.
- Misalignment:
  - SW 0x6 at address 9 -> d_misaligned=1, and word 8 is unchanged.
  - SH at address 3 -> d_misaligned=1.
  - d_size=11 -> d_misaligned=1, d_read_data=0.
- Range:
  - d_address=4096 with DEPTH=1024 and wEn=1 -> d_out_of_range=1, d_read_data=0, no write.
  - d_address=4092 -> d_out_of_range=0; a write of 0x5 there reads back 00000005.
- wEn=0 with d_write_data=4 at address 8 -> the array is unchanged over 3 cycles.
- Write 0xFFFFFFFF at 0, then assert reset 100 cycles into the clear, then release:
  - init_busy stays 1 for a further 1024 edges.
  - Address 0 reads 0.
  - Writes attempted during the clear are dropped.

Source files
------------

// File: rtl/ram_sized_access.sv
// Word RAM with an async instruction port and a sized, sign-aware data port.
// Reset runs a one-word-per-cycle clear while init_busy holds the core.
module ram_sized_access #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [DATA_WIDTH-1:0] i_read_data,
  input  logic                  wEn,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [1:0]            d_size,
  input  logic                  d_unsigned,
  input  logic [DATA_WIDTH-1:0] d_write_data,
  output logic [DATA_WIDTH-1:0] d_read_data,
  output logic                  d_misaligned,
  output logic                  d_out_of_range,
  output logic                  init_busy
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int CLR_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] DEPTH_W = (IDX_W+1)'(DEPTH);
  localparam logic [CLR_W-1:0] LAST = CLR_W'(DEPTH - 1);

  typedef enum logic {INIT, READY} state_t;

  state_t state_q, state_d;
  logic [CLR_W-1:0] clr_q, clr_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0] i_idx, d_idx;
  logic [CLR_W-1:0] i_word, d_word_i;
  logic             i_oor;
  logic [31:0]      d_word, shifted, merged, rep;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [3:0]       wmask;
  logic             is_b, is_h, is_w;
  logic             mem_we;
  logic [CLR_W-1:0] mem_addr;
  logic [31:0]      mem_wdata;
  logic             unused_bits;

  assign unused_bits = ^i_address[1:0];

  assign i_idx    = i_address[ADDR_WIDTH-1:2];
  assign d_idx    = d_address[ADDR_WIDTH-1:2];
  assign i_word   = i_idx[CLR_W-1:0];
  assign d_word_i = d_idx[CLR_W-1:0];
  assign i_oor    = {1'b0, i_idx} >= DEPTH_W;
  assign d_out_of_range = {1'b0, d_idx} >= DEPTH_W;
  assign init_busy = (state_q == INIT);

  assign i_read_data = (i_oor || init_busy) ? '0 : mem[i_word];

  assign is_b = (d_size == 2'b00);
  assign is_h = (d_size == 2'b01);
  assign is_w = (d_size == 2'b10);

  assign d_word  = mem[d_word_i];
  assign shifted = d_word >> {d_address[1:0], 3'b000};
  assign byte_v  = shifted[7:0];
  assign half_v  = d_address[1] ? d_word[31:16] : d_word[15:0];

  always_comb begin
    d_misaligned = 1'b0;
    d_read_data  = '0;
    wmask        = 4'b0000;
    rep          = d_write_data;
    unique case (1'b1)
      is_b: begin
        d_read_data = {{24{~d_unsigned & byte_v[7]}}, byte_v};
        wmask = 4'b0001 << d_address[1:0];
        rep   = {4{d_write_data[7:0]}};
      end
      is_h: begin
        d_misaligned = d_address[0];
        d_read_data  = {{16{~d_unsigned & half_v[15]}}, half_v};
        wmask = d_address[1] ? 4'b1100 : 4'b0011;
        rep   = {2{d_write_data[15:0]}};
      end
      is_w: begin
        d_misaligned = |d_address[1:0];
        d_read_data  = d_word;
        wmask = 4'b1111;
      end
      default: d_misaligned = 1'b1;
    endcase
    if (d_misaligned || d_out_of_range || init_busy)
      d_read_data = '0;
  end

  always_comb begin
    merged = d_word;
    for (int k = 0; k < 4; k++)
      if (wmask[k]) merged[8*k +: 8] = rep[8*k +: 8];
  end

  // Clear and store share the single array write port.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = d_word_i;
    mem_wdata = merged;
    if (!reset) begin
      if (init_busy) begin
        mem_we    = 1'b1;
        mem_addr  = clr_q;
        mem_wdata = '0;
      end else if (wEn && !d_misaligned && !d_out_of_range) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    if (state_q == INIT) begin
      clr_d = clr_q + CLR_W'(1);
      if (clr_q == LAST) state_d = READY;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= INIT;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

endmodule

// File: tb/tb_ram_sized_access.sv
// Bench for ram_sized_access: directed steps then random traffic
// checked against an array model of the byte-addressed RAM.
module tb_ram_sized_access;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] i_address;
  logic [31:0] i_read_data;
  logic        wEn;
  logic [15:0] d_address;
  logic [1:0]  d_size;
  logic        d_unsigned;
  logic [31:0] d_write_data;
  logic [31:0] d_read_data;
  logic        d_misaligned;
  logic        d_out_of_range;
  logic        init_busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem [1024];

  ram_sized_access #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(1024)) dut (
    .clock(clock), .reset(reset),
    .i_address(i_address), .i_read_data(i_read_data),
    .wEn(wEn), .d_address(d_address), .d_size(d_size),
    .d_unsigned(d_unsigned), .d_write_data(d_write_data),
    .d_read_data(d_read_data), .d_misaligned(d_misaligned),
    .d_out_of_range(d_out_of_range), .init_busy(init_busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_mis(input int addr, input int size);
    return size == 3 || (size == 1 && addr % 2 != 0) ||
           (size == 2 && addr % 4 != 0);
  endfunction

  function automatic bit m_oor(input int addr);
    return addr / 4 >= 1024;
  endfunction

  function automatic logic [31:0] m_read(input int addr, input int size,
                                         input bit uns);
    logic [31:0] w, v;
    if (m_mis(addr, size) || m_oor(addr)) return 32'h0;
    w = ref_mem[addr / 4];
    if (size == 0) begin
      v = (w >> (8 * (addr % 4))) & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (size == 1) begin
      v = (w >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_ifetch(input int addr);
    return (addr / 4 >= 1024) ? 32'h0 : ref_mem[addr / 4];
  endfunction

  task automatic m_write(input int addr, input int size,
                         input logic [31:0] data);
    logic [31:0] mask, w;
    int sh;
    if (m_mis(addr, size) || m_oor(addr)) return;
    w = ref_mem[addr / 4];
    if (size == 0) begin
      sh = 8 * (addr % 4);
      mask = 32'hFF << sh;
      w = (w & ~mask) | ((data & 32'hFF) << sh);
    end else if (size == 1) begin
      sh = 16 * ((addr / 2) % 2);
      mask = 32'hFFFF << sh;
      w = (w & ~mask) | ((data & 32'hFFFF) << sh);
    end else begin
      w = data;
    end
    ref_mem[addr / 4] = w;
  endtask

  task automatic set_d(input int addr, input int size, input bit uns);
    d_address  = 16'(addr);
    d_size     = 2'(size);
    d_unsigned = uns;
    #1;
  endtask

  task automatic store(input int addr, input int size,
                       input logic [31:0] data);
    d_address    = 16'(addr);
    d_size       = 2'(size);
    d_write_data = data;
    wEn          = 1'b1;
    @(posedge clock);
    #1;
    wEn = 1'b0;
    m_write(addr, size, data);
  endtask

  task automatic load(input string tag, input int addr, input int size,
                      input bit uns, input logic [31:0] exp);
    set_d(addr, size, uns);
    chk(tag, d_read_data, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
  endtask

  initial begin
    int n, a, sz;
    bit u, we;
    logic [31:0] wd;

    reset = 1'b1;
    wEn = 1'b0;
    i_address = '0;
    d_address = '0;
    d_size = 2'b10;
    d_unsigned = 1'b0;
    d_write_data = '0;

    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("busy_in_reset", 32'(init_busy), 32'h1);
    reset = 1'b0;
    n = 0;
    while (init_busy && n < 2000) begin
      if (n == 5) begin
        load("read4_during_clear", 4, 2, 1'b0, 32'h0);
        i_address = 16'd4; #1;
        chk("ifetch_during_clear", i_read_data, 32'h0);
      end
      @(posedge clock); #1;
      n++;
    end
    chk("clear_edges", 32'(n), 32'd1024);
    model_clear();
    load("after_clear_0", 0, 2, 1'b0, 32'h0);
    load("after_clear_4", 4, 2, 1'b0, 32'h0);
    load("after_clear_4092", 4092, 2, 1'b0, 32'h0);

    store(8, 2, 32'h11223344);
    store(9, 0, 32'h000000AA);
    store(10, 1, 32'h0000BEEF);
    load("lw8", 8, 2, 1'b0, 32'hBEEFAA44);
    load("lb9_s", 9, 0, 1'b0, 32'hFFFFFFAA);
    load("lb9_u", 9, 0, 1'b1, 32'h000000AA);
    load("lh10_s", 10, 1, 1'b0, 32'hFFFFBEEF);
    i_address = 16'd8; #1;
    chk("ifetch8", i_read_data, 32'hBEEFAA44);

    set_d(9, 2, 1'b0);
    chk("mis_sw9", 32'(d_misaligned), 32'h1);
    store(9, 2, 32'h6);
    load("lw8_after_mis", 8, 2, 1'b0, 32'hBEEFAA44);
    set_d(3, 1, 1'b0);
    chk("mis_sh3", 32'(d_misaligned), 32'h1);
    store(3, 1, 32'h1234);
    load("lw0_after_mis", 0, 2, 1'b0, 32'h0);
    set_d(8, 3, 1'b0);
    chk("mis_size3", 32'(d_misaligned), 32'h1);
    chk("rd_size3", d_read_data, 32'h0);

    set_d(4096, 2, 1'b0);
    chk("oor_4096", 32'(d_out_of_range), 32'h1);
    chk("rd_4096", d_read_data, 32'h0);
    store(4096, 2, 32'hDEADBEEF);
    load("lw0_after_oor", 0, 2, 1'b0, 32'h0);
    set_d(4092, 2, 1'b0);
    chk("oor_4092", 32'(d_out_of_range), 32'h0);
    store(4092, 2, 32'h5);
    load("lw4092", 4092, 2, 1'b0, 32'h00000005);

    d_address = 16'd8; d_size = 2'b10; d_write_data = 32'h4; wEn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    load("wen0_hold", 8, 2, 1'b0, 32'hBEEFAA44);

    for (int t = 0; t < 300; t++) begin
      a  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4096, 65535))
                                       : int'($urandom_range(0, 4095));
      sz = int'($urandom_range(0, 3));
      u  = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      i_address = 16'($urandom_range(0, 4200));
      set_d(a, sz, u);
      chk("rnd_mis", 32'(d_misaligned), 32'(m_mis(a, sz)));
      chk("rnd_oor", 32'(d_out_of_range), 32'(m_oor(a)));
      chk("rnd_rd", d_read_data, m_read(a, sz, u));
      chk("rnd_if", i_read_data, m_ifetch(int'(i_address)));
      if (we) store(a, sz, wd);
      else begin
        @(posedge clock); #1;
      end
    end

    store(0, 2, 32'hFFFFFFFF);
    load("lw0_ones", 0, 2, 1'b0, 32'hFFFFFFFF);
    reset = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (100) @(posedge clock);
    #1;
    chk("busy_mid_clear", 32'(init_busy), 32'h1);
    i_address = 16'd0; #1;
    chk("if0_mid_clear", i_read_data, 32'h0);
    d_address = 16'd0; d_size = 2'b10; d_write_data = 32'hFFFFFFFF;
    wEn = 1'b1;
    @(posedge clock); #1;
    wEn = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    n = 0;
    while (init_busy && n < 2000) begin
      if (n == 50) begin
        d_address = 16'd0; d_write_data = 32'hA5A5A5A5; wEn = 1'b1;
      end else begin
        wEn = 1'b0;
      end
      @(posedge clock); #1;
      n++;
    end
    wEn = 1'b0;
    chk("reclear_edges", 32'(n), 32'd1024);
    model_clear();
    load("lw0_after_reclear", 0, 2, 1'b0, 32'h0);
    load("lw8_after_reclear", 8, 2, 1'b0, 32'h0);
    i_address = 16'd4092; #1;
    chk("if4092_after_reclear", i_read_data, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
